rtio_time_controller: RTL and testbench



---
 rtl/rtio_time_controller.sv | 167 ++++++++++++++++
 tb/tb_rtio_time_controller.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtio_time_controller.sv
// RTIO timebase: the 64-bit counter and the one-cycle auto_start strobe shared by every RTO core.
// A command port loads a start time, arms a start delay, starts/stops the count and clears sticky errors.
module rtio_time_controller #(
  parameter int COUNTER_WIDTH = 64,
  parameter int DELAY_WIDTH   = 32
) (
  input  logic                     rtio_clk,
  input  logic                     rtio_aresetn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [COUNTER_WIDTH-1:0] cmd_value,
  output logic [COUNTER_WIDTH-1:0] counter,
  output logic                     auto_start,
  output logic                     running,
  output logic                     armed,
  output logic                     cmd_error,
  output logic                     overflow
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUNNING} state_t;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_START = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [COUNTER_WIDTH-1:0] r_counter;
  logic [COUNTER_WIDTH-1:0] r_load_reg;
  logic [DELAY_WIDTH-1:0]   r_delay_cnt;
  logic                     r_auto_start;
  logic                     r_running;
  logic                     r_armed;
  logic                     r_cmd_error;
  logic                     r_overflow;

  logic [COUNTER_WIDTH-1:0] w_counter_nxt;
  logic [COUNTER_WIDTH-1:0] w_load_nxt;
  logic [DELAY_WIDTH-1:0]   w_delay_nxt;
  logic                     w_auto_nxt;
  logic                     w_error_nxt;
  logic                     w_overflow_nxt;
  logic                     w_accept;
  logic                     w_wrap;

  assign cmd_ready  = (r_state != S_ARMED);
  assign w_accept   = cmd_valid & cmd_ready;
  assign w_wrap     = &r_counter;

  assign counter    = r_counter;
  assign auto_start = r_auto_start;
  assign running    = r_running;
  assign armed      = r_armed;
  assign cmd_error  = r_cmd_error;
  assign overflow   = r_overflow;

  always_ff @(posedge rtio_clk or negedge rtio_aresetn) begin
    if (!rtio_aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (cmd_op == OP_START)) begin
          w_next_state = S_ARMED;
        end
      end
      S_ARMED: begin
        if (r_delay_cnt == '0) begin
          w_next_state = S_RUNNING;
        end
      end
      S_RUNNING: begin
        if (w_accept && (cmd_op == OP_STOP)) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Wrap detection is applied after command handling so a wrap beats a same-edge CLEAR_ERR.
  always_comb begin
    w_counter_nxt  = r_counter;
    w_load_nxt     = r_load_reg;
    w_delay_nxt    = r_delay_cnt;
    w_auto_nxt     = 1'b0;
    w_error_nxt    = r_cmd_error;
    w_overflow_nxt = r_overflow;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_LOAD: begin
              w_load_nxt    = cmd_value;
              w_counter_nxt = cmd_value;
            end
            OP_START: begin
              w_delay_nxt   = cmd_value[DELAY_WIDTH-1:0];
              w_counter_nxt = r_load_reg;
            end
            OP_CLEAR: begin
              w_error_nxt    = 1'b0;
              w_overflow_nxt = 1'b0;
            end
            default: ;
          endcase
        end
      end
      S_ARMED: begin
        w_counter_nxt = r_load_reg;
        if (r_delay_cnt == '0) begin
          w_auto_nxt = 1'b1;
        end else begin
          w_delay_nxt = r_delay_cnt - DELAY_WIDTH'(1);
        end
      end
      S_RUNNING: begin
        w_counter_nxt = r_counter + COUNTER_WIDTH'(1);
        if (w_accept) begin
          case (cmd_op)
            OP_LOAD, OP_START: w_error_nxt = 1'b1;
            OP_CLEAR: begin
              w_error_nxt    = 1'b0;
              w_overflow_nxt = 1'b0;
            end
            default: ;
          endcase
        end
        if (w_wrap) begin
          w_overflow_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rtio_clk or negedge rtio_aresetn) begin
    if (!rtio_aresetn) begin
      r_counter    <= '0;
      r_load_reg   <= '0;
      r_delay_cnt  <= '0;
      r_auto_start <= 1'b0;
      r_running    <= 1'b0;
      r_armed      <= 1'b0;
      r_cmd_error  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_counter    <= w_counter_nxt;
      r_load_reg   <= w_load_nxt;
      r_delay_cnt  <= w_delay_nxt;
      r_auto_start <= w_auto_nxt;
      r_running    <= (w_next_state == S_RUNNING);
      r_armed      <= (w_next_state == S_ARMED);
      r_cmd_error  <= w_error_nxt;
      r_overflow   <= w_overflow_nxt;
    end
  end

endmodule

// File: tb/tb_rtio_time_controller.sv
// Directed bench for rtio_time_controller: start delay, wrap/overflow, illegal commands, STOP, async reset.
// Status vector bits are {cmd_ready, auto_start, running, armed, cmd_error, overflow}.
module tb_rtio_time_controller;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_START = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam logic [5:0] ST_IDLE  = 6'b100000;
  localparam logic [5:0] ST_ARMED = 6'b000100;
  localparam logic [5:0] ST_AUTO  = 6'b111000;
  localparam logic [5:0] ST_RUN   = 6'b101000;

  localparam logic [63:0] ONES = {64{1'b1}};

  logic        rtio_clk;
  logic        rtio_aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [63:0] cmd_value;
  logic [63:0] counter;
  logic        auto_start;
  logic        running;
  logic        armed;
  logic        cmd_error;
  logic        overflow;
  logic [5:0]  stat;

  int vectors;
  int miscompares;

  assign stat = {cmd_ready, auto_start, running, armed, cmd_error, overflow};

  rtio_time_controller #(.COUNTER_WIDTH(64), .DELAY_WIDTH(32)) dut (
    .rtio_clk    (rtio_clk),
    .rtio_aresetn(rtio_aresetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_value   (cmd_value),
    .counter     (counter),
    .auto_start  (auto_start),
    .running     (running),
    .armed       (armed),
    .cmd_error   (cmd_error),
    .overflow    (overflow)
  );

  initial rtio_clk = 1'b0;
  always #5 rtio_clk = ~rtio_clk;

  task automatic step();
    @(posedge rtio_clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [63:0] val);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_value = val;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rtio_aresetn = 1'b0;
    cmd_valid    = 1'b0;
    cmd_op       = OP_LOAD;
    cmd_value    = '0;
    step();
    step();
    vectors++;
    if (stat !== ST_IDLE) begin
      miscompares++;
      $display("[TB] FAIL reset_status got=%b exp=%b", stat, ST_IDLE);
    end
    vectors++;
    if (counter !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_counter got=%h exp=%h", counter, 64'h0);
    end
    rtio_aresetn = 1'b1;
    step();
  endtask

  task automatic test_start_delay();
    send(OP_LOAD, 64'h100);
    vectors++;
    if (counter !== 64'h100 || stat !== ST_IDLE) begin
      miscompares++;
      $display("[TB] FAIL load got=%h/%b exp=%h/%b", counter, stat, 64'h100, ST_IDLE);
    end
    send(OP_START, 64'd3);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (counter !== 64'h100 || stat !== ST_ARMED) begin
        miscompares++;
        $display("[TB] FAIL armed_cycle%0d got=%h/%b exp=%h/%b", i, counter, stat, 64'h100, ST_ARMED);
      end
      step();
    end
    vectors++;
    if (counter !== 64'h100 || stat !== ST_AUTO) begin
      miscompares++;
      $display("[TB] FAIL auto_start got=%h/%b exp=%h/%b", counter, stat, 64'h100, ST_AUTO);
    end
    for (int i = 1; i <= 2; i++) begin
      step();
      vectors++;
      if (counter !== 64'h100 + 64'(i) || stat !== ST_RUN) begin
        miscompares++;
        $display("[TB] FAIL run_incr%0d got=%h/%b exp=%h/%b", i, counter, stat, 64'h100 + 64'(i), ST_RUN);
      end
    end
    send(OP_STOP, 64'h0);
    vectors++;
    if (counter !== 64'h103 || stat !== ST_IDLE) begin
      miscompares++;
      $display("[TB] FAIL stop got=%h/%b exp=%h/%b", counter, stat, 64'h103, ST_IDLE);
    end
    step();
    vectors++;
    if (counter !== 64'h103) begin
      miscompares++;
      $display("[TB] FAIL stop_frozen got=%h exp=%h", counter, 64'h103);
    end
  endtask

  task automatic test_wrap_and_errors();
    send(OP_LOAD, ONES - 64'd1);
    send(OP_START, 64'd0);
    vectors++;
    if (counter !== ONES - 64'd1 || stat !== ST_ARMED) begin
      miscompares++;
      $display("[TB] FAIL wrap_armed got=%h/%b exp=%h/%b", counter, stat, ONES - 64'd1, ST_ARMED);
    end
    step();
    vectors++;
    if (counter !== ONES - 64'd1 || stat !== ST_AUTO) begin
      miscompares++;
      $display("[TB] FAIL wrap_auto got=%h/%b exp=%h/%b", counter, stat, ONES - 64'd1, ST_AUTO);
    end
    step();
    vectors++;
    if (counter !== ONES || stat !== ST_RUN) begin
      miscompares++;
      $display("[TB] FAIL wrap_ff got=%h/%b exp=%h/%b", counter, stat, ONES, ST_RUN);
    end
    step();
    vectors++;
    if (counter !== 64'h0 || stat !== (ST_RUN | 6'b000001)) begin
      miscompares++;
      $display("[TB] FAIL wrap_zero got=%h/%b exp=%h/%b", counter, stat, 64'h0, ST_RUN | 6'b000001);
    end
    step();
    vectors++;
    if (counter !== 64'h1 || overflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ovf_sticky got=%h/%b exp=%h/1", counter, overflow, 64'h1);
    end
    send(OP_CLEAR, 64'h0);
    vectors++;
    if (counter !== 64'h2 || stat !== ST_RUN) begin
      miscompares++;
      $display("[TB] FAIL ovf_clear got=%h/%b exp=%h/%b", counter, stat, 64'h2, ST_RUN);
    end
    send(OP_LOAD, 64'h5);
    vectors++;
    if (counter !== 64'h3 || stat !== (ST_RUN | 6'b000010)) begin
      miscompares++;
      $display("[TB] FAIL illegal_load got=%h/%b exp=%h/%b", counter, stat, 64'h3, ST_RUN | 6'b000010);
    end
    send(OP_START, 64'h7);
    vectors++;
    if (counter !== 64'h4 || stat !== (ST_RUN | 6'b000010)) begin
      miscompares++;
      $display("[TB] FAIL illegal_start got=%h/%b exp=%h/%b", counter, stat, 64'h4, ST_RUN | 6'b000010);
    end
    send(OP_CLEAR, 64'h0);
    vectors++;
    if (counter !== 64'h5 || stat !== ST_RUN) begin
      miscompares++;
      $display("[TB] FAIL err_clear got=%h/%b exp=%h/%b", counter, stat, 64'h5, ST_RUN);
    end
    send(OP_STOP, 64'h0);
    vectors++;
    if (counter !== 64'h6 || stat !== ST_IDLE) begin
      miscompares++;
      $display("[TB] FAIL wrap_stop got=%h/%b exp=%h/%b", counter, stat, 64'h6, ST_IDLE);
    end
  endtask

  task automatic test_set_wins_and_restart();
    send(OP_LOAD, ONES);
    send(OP_START, 64'd0);
    step();
    send(OP_CLEAR, 64'h0);
    vectors++;
    if (counter !== 64'h0 || stat !== (ST_RUN | 6'b000001)) begin
      miscompares++;
      $display("[TB] FAIL set_wins got=%h/%b exp=%h/%b", counter, stat, 64'h0, ST_RUN | 6'b000001);
    end
    send(OP_STOP, 64'h0);
    send(OP_CLEAR, 64'h0);
    vectors++;
    if (counter !== 64'h1 || stat !== ST_IDLE) begin
      miscompares++;
      $display("[TB] FAIL idle_clear got=%h/%b exp=%h/%b", counter, stat, 64'h1, ST_IDLE);
    end
    send(OP_START, 64'd0);
    vectors++;
    if (counter !== ONES || stat !== ST_ARMED) begin
      miscompares++;
      $display("[TB] FAIL restart_load got=%h/%b exp=%h/%b", counter, stat, ONES, ST_ARMED);
    end
    step();
    vectors++;
    if (counter !== ONES || stat !== ST_AUTO) begin
      miscompares++;
      $display("[TB] FAIL restart_auto got=%h/%b exp=%h/%b", counter, stat, ONES, ST_AUTO);
    end
    send(OP_STOP, 64'h0);
    vectors++;
    if (counter !== 64'h0 || stat !== (ST_IDLE | 6'b000001)) begin
      miscompares++;
      $display("[TB] FAIL stop_on_wrap got=%h/%b exp=%h/%b", counter, stat, 64'h0, ST_IDLE | 6'b000001);
    end
    send(OP_CLEAR, 64'h0);
  endtask

  task automatic test_back_to_back();
    send(OP_LOAD, 64'h20);
    cmd_valid = 1'b1;
    cmd_op    = OP_START;
    cmd_value = 64'd10;
    step();
    cmd_op = OP_STOP;
    for (int i = 0; i < 11; i++) begin
      vectors++;
      if (stat !== ST_ARMED || counter !== 64'h20) begin
        miscompares++;
        $display("[TB] FAIL held_armed%0d got=%h/%b exp=%h/%b", i, counter, stat, 64'h20, ST_ARMED);
      end
      step();
    end
    vectors++;
    if (counter !== 64'h20 || stat !== ST_AUTO) begin
      miscompares++;
      $display("[TB] FAIL held_auto got=%h/%b exp=%h/%b", counter, stat, 64'h20, ST_AUTO);
    end
    step();
    cmd_valid = 1'b0;
    vectors++;
    if (counter !== 64'h21 || stat !== ST_IDLE) begin
      miscompares++;
      $display("[TB] FAIL held_stop got=%h/%b exp=%h/%b", counter, stat, 64'h21, ST_IDLE);
    end
    step();
    vectors++;
    if (counter !== 64'h21) begin
      miscompares++;
      $display("[TB] FAIL held_frozen got=%h exp=%h", counter, 64'h21);
    end
  endtask

  task automatic test_reset_mid(input logic [63:0] delay, input int wait_cycles, input string tag);
    send(OP_LOAD, 64'h40);
    send(OP_START, delay);
    for (int i = 0; i < wait_cycles; i++) step();
    #3;
    rtio_aresetn = 1'b0;
    #1;
    vectors++;
    if (counter !== 64'h0 || stat !== ST_IDLE) begin
      miscompares++;
      $display("[TB] FAIL %s_async got=%h/%b exp=%h/%b", tag, counter, stat, 64'h0, ST_IDLE);
    end
    step();
    rtio_aresetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++;
      if (counter !== 64'h0 || stat !== ST_IDLE) begin
        miscompares++;
        $display("[TB] FAIL %s_release%0d got=%h/%b exp=%h/%b", tag, i, counter, stat, 64'h0, ST_IDLE);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_start_delay();
    test_wrap_and_errors();
    test_set_wins_and_restart();
    test_back_to_back();
    test_reset_mid(64'd5, 2, "mid_armed");
    test_reset_mid(64'd0, 4, "mid_running");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
